seg_scan_sched: RTL and testbench



---
 rtl/seg_scan_sched_if.sv | 22 ++
 rtl/seg_scan_sched.sv | 186 ++++++++++++++++++
 tb/tb_seg_scan_sched.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_sched_if.sv
// Display-side signal bundle for seg_scan_sched: value/sign/point/enable
// from the application, sel/seg towards the 74HC595 driver.
interface seg_scan_sched_if;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  // Application side: supplies the value, reads back the scan outputs.
  modport master (
    output data, point, sign, seg_en,
    input  sel, seg
  );

  // Scheduler side.
  modport slave (
    input  data, point, sign, seg_en,
    output sel, seg
  );
endinterface

// File: rtl/seg_scan_sched.sv
// Six-digit seven-segment scan scheduler. Samples a binary value once per
// frame, converts it to BCD with a sequential double-dabble engine, applies
// leading-zero blanking and a minus sign, and multiplexes the digits onto a
// registered one-hot sel / active-low seg pair for hc595_ctrl.
module seg_scan_sched #(
  parameter int unsigned CNT_MAX = 49_999
) (
  input logic          sys_clk,
  input logic          sys_rst_n,
  seg_scan_sched_if.slave bus
);

  localparam int unsigned CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [19:0] DATA_MAX = 20'd999_999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  // Scan timing
  logic [CNT_W-1:0] cnt_dwell;
  logic [2:0]       digit_idx;
  logic             first_q;
  logic             dwell_wrap;
  logic             frame_start;

  // Converter
  conv_state_t state;
  logic [4:0]  iter;
  logic [23:0] bcd;
  logic [23:0] bcd_adj;
  logic [19:0] shreg;
  logic        sign_sh;
  logic [5:0]  point_sh;

  // Display registers: one consistent frame sample
  logic [23:0] disp_bcd;
  logic        disp_sign;
  logic [5:0]  disp_point;

  // Output path
  logic [2:0] msd;
  logic [7:0] digit_pat;
  logic [5:0] sel_q;
  logic [7:0] seg_q;

  // Active-low {dp,g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  assign dwell_wrap  = (cnt_dwell == CNT_W'(CNT_MAX));
  assign frame_start = first_q | (dwell_wrap & (digit_idx == 3'd5));

  // Dwell counter and digit index; first_q marks the first cycle after reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_dwell <= '0;
      digit_idx <= 3'd0;
      first_q   <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (dwell_wrap) begin
        cnt_dwell <= '0;
        digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
      end else begin
        cnt_dwell <= cnt_dwell + 1'b1;
      end
    end
  end

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable holding its old value, which would infer a latch.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM: sample on frame start, 20 shift-add-3 steps, then publish.
  // NOTE: the display registers are reset along with the FSM so a reset
  // mid-conversion never leaves a half-updated frame on the digits.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      iter       <= 5'd0;
      bcd        <= '0;
      shreg      <= '0;
      sign_sh    <= 1'b0;
      point_sh   <= '0;
      disp_bcd   <= '0;
      disp_sign  <= 1'b0;
      disp_point <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            shreg    <= (bus.data > DATA_MAX) ? DATA_MAX : bus.data;
            sign_sh  <= bus.sign;
            point_sh <= bus.point;
            bcd      <= '0;
            iter     <= 5'd0;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd   <= (bcd_adj << 1) | {23'd0, shreg[19]};
          shreg <= shreg << 1;
          iter  <= iter + 5'd1;
          if (iter == 5'd19) begin
            state <= DONE;
          end
        end
        DONE: begin
          disp_bcd   <= bcd;
          disp_sign  <= sign_sh;
          disp_point <= point_sh;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Most significant shown digit: highest nonzero digit or lit point, else 0.
  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if ((disp_bcd[4*i +: 4] != 4'd0) || disp_point[i]) begin
        msd = 3'(i);
      end
    end
  end

  // Pattern for the digit being scanned: value, minus sign, or blank.
  always_comb begin
    digit_pat = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      if (digit_idx == 3'(i)) begin
        if (3'(i) <= msd) begin
          digit_pat = seg_decode(disp_bcd[4*i +: 4]) & ~{disp_point[i], 7'd0};
        end else if (disp_sign && (msd < 3'd5) && (3'(i) == msd + 3'd1)) begin
          digit_pat = 8'hBF;
        end
      end
    end
  end

  // Registered outputs, forced dark while the display is disabled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_q <= 6'b000000;
      seg_q <= 8'hFF;
    end else if (bus.seg_en) begin
      sel_q <= 6'b000001 << digit_idx;
      seg_q <= digit_pat;
    end else begin
      sel_q <= 6'b000000;
      seg_q <= 8'hFF;
    end
  end

  assign bus.sel = sel_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Self-checking bench for seg_scan_sched: a reference model computes each
// digit's expected pattern from the displayed value with decimal arithmetic;
// expected digits go into a queue and a monitor compares them as the scan
// presents each digit.
module tb_seg_scan_sched;

  localparam int CNT_MAX = 99;
  localparam int FRAME   = 6 * (CNT_MAX + 1);

  localparam logic [7:0] DEC_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    logic [5:0] sel;
    logic [7:0] seg;
    int         digit;
  } exp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  seg_scan_sched_if bus ();

  seg_scan_sched #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string cur_tag = "init";

  // Currently applied inputs, the source of every expectation.
  int       cur_val   = 0;
  bit       cur_sign  = 1'b0;
  bit [5:0] cur_point = 6'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the display", name);
  endtask

  // Reference model: pattern digit i should show for a given input triple.
  function automatic logic [7:0] ref_seg(input int value, input bit sgn,
                                         input bit [5:0] pt, input int i);
    int         v;
    int         d [6];
    int         msd;
    logic [7:0] p;
    v = (value > 999999) ? 999999 : value;
    for (int k = 0; k < 6; k++) begin
      d[k] = v % 10;
      v    = v / 10;
    end
    msd = 0;
    for (int k = 0; k < 6; k++) begin
      if (d[k] != 0 || pt[k]) msd = k;
    end
    if (i <= msd) begin
      p = DEC_TAB[d[i]];
      if (pt[i]) p[7] = 1'b0;
    end else if (sgn && msd < 5 && i == msd + 1) begin
      p = 8'hBF;
    end else begin
      p = 8'hFF;
    end
    return p;
  endfunction

  // Monitor: each time a new digit is selected, compare it with the next expectation.
  initial begin
    logic [5:0] prev_sel;
    exp_t       e;
    prev_sel = 6'd0;
    forever begin
      @(negedge sys_clk);
      if (bus.sel !== prev_sel && bus.sel !== 6'd0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s d%0d sel", cur_tag, e.digit), 32'(bus.sel), 32'(e.sel));
        check($sformatf("%s d%0d seg", cur_tag, e.digit), 32'(bus.seg), 32'(e.seg));
      end
      prev_sel = bus.sel;
    end
  end

  task automatic apply(input int v, input bit s, input bit [5:0] p);
    @(negedge sys_clk);
    bus.data  = 20'(v);
    bus.sign  = s;
    bus.point = p;
    cur_val   = v;
    cur_sign  = s;
    cur_point = p;
  endtask

  task automatic wait_sel(input logic [5:0] target);
    int n;
    n = 0;
    while (bus.sel !== target && n < 2 * FRAME) begin
      @(negedge sys_clk);
      n++;
    end
    if (bus.sel !== target) timeout_fail($sformatf("%s wait sel=%b", cur_tag, target));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < FRAME + 200) begin
      @(negedge sys_clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      timeout_fail($sformatf("%s drain", cur_tag));
      exp_q.delete();
    end
  endtask

  task automatic push_digit(input int i, input int v, input bit s, input bit [5:0] p);
    exp_t e;
    e.sel   = 6'b000001 << i;
    e.seg   = ref_seg(v, s, p, i);
    e.digit = i;
    exp_q.push_back(e);
  endtask

  // Queue one whole frame of the current value, starting at digit 0.
  task automatic check_frame(input string tag);
    cur_tag = tag;
    wait_sel(6'b100000);
    @(posedge sys_clk);
    for (int i = 0; i < 6; i++) push_digit(i, cur_val, cur_sign, cur_point);
    drain();
  endtask

  task automatic show(input string tag, input int v, input bit s, input bit [5:0] p);
    apply(v, s, p);
    repeat (FRAME + 30) @(posedge sys_clk);
    check_frame(tag);
  endtask

  // Pulse reset with new inputs, then check digit 0 around the 22-cycle latency.
  task automatic release_and_latency(input string tag, input logic [7:0] old_pat);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (22) @(posedge sys_clk);
    #1;
    check({tag, " pre-update sel"}, 32'(bus.sel), 32'(6'b000001));
    check({tag, " pre-update seg"}, 32'(bus.seg), 32'(old_pat));
    @(posedge sys_clk);
    #1;
    check({tag, " post-update seg"}, 32'(bus.seg), 32'(ref_seg(cur_val, cur_sign, cur_point, 0)));
  endtask

  initial begin
    int       v;
    bit       s;
    bit [5:0] p;
    int       a_val;
    int       b_val;

    bus.data   = 20'd0;
    bus.point  = 6'd0;
    bus.sign   = 1'b0;
    bus.seg_en = 1'b1;

    // Reset state, then zero.
    repeat (3) @(negedge sys_clk);
    check("reset sel", 32'(bus.sel), 32'(6'b000000));
    check("reset seg", 32'(bus.seg), 32'(8'hFF));
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    check("first digit sel", 32'(bus.sel), 32'(6'b000001));
    check("first digit seg", 32'(bus.seg), 32'(8'hC0));
    check_frame("zero");

    // Directed values: full value, sign/blanking, points, saturation.
    show("full",      123456,   1'b0, 6'b000000);
    show("sign42",    42,       1'b1, 6'b000000);
    show("sign6dig",  654321,   1'b1, 6'b000000);
    show("point5",    5,        1'b0, 6'b000010);
    show("saturate",  20'hFFFFF, 1'b0, 6'b000000);
    show("negzero",   0,        1'b1, 6'b000000);
    show("top5sign",  100000,   1'b1, 6'b000000);
    show("pointtop",  7,        1'b1, 6'b100000);

    // Random values of varied magnitude.
    for (int n = 0; n < 6; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 9999);
        2:       v = $urandom_range(0, 999999);
        default: v = $urandom_range(0, 20'hFFFFF);
      endcase
      s = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63)) : 6'd0;
      show($sformatf("rand%0d", n), v, s, p);
    end

    // Mid-frame change: rest of the frame and the start of digit 0 keep A.
    a_val = 135790;
    b_val = 246802;
    show("frameA", a_val, 1'b0, 6'd0);
    cur_tag = "midframe";
    wait_sel(6'b000100);
    @(posedge sys_clk);
    for (int i = 3; i < 6; i++) push_digit(i, a_val, 1'b0, 6'd0);
    push_digit(0, a_val, 1'b0, 6'd0);
    apply(b_val, 1'b0, 6'd0);
    drain();
    repeat (24) @(posedge sys_clk);
    #1;
    check("midframe new d0 sel", 32'(bus.sel), 32'(6'b000001));
    check("midframe new d0 seg", 32'(bus.seg), 32'(ref_seg(b_val, 1'b0, 6'd0, 0)));
    check_frame("frameB");

    // Disable and re-enable while digit 2 is being shown.
    cur_tag = "seg_en";
    wait_sel(6'b000100);
    bus.seg_en = 1'b0;
    @(posedge sys_clk);
    #1;
    check("disable sel", 32'(bus.sel), 32'(6'b000000));
    check("disable seg", 32'(bus.seg), 32'(8'hFF));
    @(negedge sys_clk);
    bus.seg_en = 1'b1;
    @(posedge sys_clk);
    #1;
    check("enable sel", 32'(bus.sel), 32'(6'b000100));
    check("enable seg", 32'(bus.seg), 32'(ref_seg(b_val, 1'b0, 6'd0, 2)));

    // Conversion latency from reset release: 123456 lands 22 cycles later.
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    apply(123456, 1'b0, 6'd0);
    release_and_latency("latency", 8'hC0);

    // Reset mid-conversion: display returns to zero, fresh conversion completes.
    apply(654321, 1'b0, 6'd0);
    repeat (10) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("async reset sel", 32'(bus.sel), 32'(6'b000000));
    check("async reset seg", 32'(bus.seg), 32'(8'hFF));
    release_and_latency("reconv", 8'hC0);
    check_frame("after reconv");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
